// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and default parameters for the clock-enable /
// divided-clock generator (clk_div_gen and its prescaler).
package clk_div_pkg;

    localparam int P_CNT_W    = 16;  // half-period counter width
    localparam int P_DEF_HALF = 1;   // half-period loaded at reset (clk/2)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } div_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: 2-bit free-running prescaler producing 50 MHz and 25 MHz
// single-cycle enables from the 100 MHz system clock.
// Ports:
//   i_clk     system clock
//   i_rst_n   synchronous active-low reset
//   i_en      run enable; prescaler holds and ticks are 0 while low
//   o_tick50  pulse every 2nd enabled cycle
//   o_tick25  pulse every 4th enabled cycle (coincides with every 2nd tick50)
module tick_prescaler (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick50,
    output logic o_tick25
);

    logic [1:0] r_ps;
    logic       r_tick50;
    logic       r_tick25;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ps     <= 2'd0;
            r_tick50 <= 1'b0;
            r_tick25 <= 1'b0;
        end else begin
            r_tick50 <= i_en & r_ps[0];
            r_tick25 <= i_en & (r_ps == 2'b11);
            if (i_en)
                r_ps <= r_ps + 2'd1;
        end
    end

    assign o_tick50 = r_tick50;
    assign o_tick25 = r_tick25;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock-enable and divided-clock generator.
// Produces 50/25 MHz tick enables plus a square wave that is H cycles high
// and H cycles low, with H reprogrammable through a valid/ready handshake.
// A new H requested while running is held as pending and applied only at the
// end of a full period, so no output phase is shorter than min(old H, new H).
// Ports:
//   i_clk        system clock (100 MHz)
//   i_rst_n      synchronous active-low reset
//   i_en         run enable for prescaler and divider
//   i_cfg_valid  new half-period offered
//   o_cfg_ready  divider accepts i_cfg_half this cycle (low while reloading)
//   i_cfg_half   requested half-period in clk cycles (0 treated as 1)
//   o_tick50     50 MHz enable pulse
//   o_tick25     25 MHz enable pulse
//   o_div_clk    programmable square wave
//   o_div_tick   pulse in the first cycle o_div_clk reads 1
//   o_busy       high while a pending half-period waits for the period end
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = P_CNT_W,
    parameter int DEF_HALF = P_DEF_HALF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CNT_W-1:0] i_cfg_half,
    output logic             o_tick50,
    output logic             o_tick25,
    output logic             o_div_clk,
    output logic             o_div_tick,
    output logic             o_busy
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div_clk;
    logic             r_div_tick;
    logic             r_busy;
    logic             r_cfg_ready;

    logic             w_xfer;
    logic [CNT_W-1:0] w_cfg_val;
    logic             w_term;

    tick_prescaler u_ps (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_en),
        .o_tick50 (o_tick50),
        .o_tick25 (o_tick25)
    );

    assign w_xfer    = i_cfg_valid & r_cfg_ready;
    // A zero half-period would never hit the terminal count; clamp to 1.
    assign w_cfg_val = (i_cfg_half == '0) ? CNT_W'(1) : i_cfg_half;
    // r_half is never 0, so half-1 cannot underflow.
    assign w_term    = (r_cnt == r_half - CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_half      <= CNT_W'(DEF_HALF);
            r_pend      <= '0;
            r_cnt       <= '0;
            r_div_clk   <= 1'b0;
            r_div_tick  <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_div_tick <= 1'b0;
            if (!i_en) begin
                // Dropping enable wins over everything; a waiting value is
                // not lost but committed directly.
                if (r_state == RELOAD)
                    r_half <= r_pend;
                else if (w_xfer)
                    r_half <= w_cfg_val;
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_div_clk   <= 1'b0;
                r_busy      <= 1'b0;
                r_cfg_ready <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_xfer)
                            r_half <= w_cfg_val;
                        r_state   <= RUN;
                        r_cnt     <= '0;
                        r_div_clk <= 1'b0;
                    end
                    RUN, RELOAD: begin
                        if (w_term) begin
                            r_cnt      <= '0;
                            r_div_clk  <= ~r_div_clk;
                            r_div_tick <= ~r_div_clk;
                            // Falling toggle ends a full period: safe point
                            // to switch half-period.
                            if (r_state == RELOAD && r_div_clk) begin
                                r_half      <= r_pend;
                                r_state     <= RUN;
                                r_busy      <= 1'b0;
                                r_cfg_ready <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (r_state == RUN && w_xfer) begin
                            r_pend      <= w_cfg_val;
                            r_state     <= RELOAD;
                            r_busy      <= 1'b1;
                            r_cfg_ready <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_div_clk   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_div_clk   = r_div_clk;
    assign o_div_tick  = r_div_tick;
    assign o_busy      = r_busy;
    assign o_cfg_ready = r_cfg_ready;

endmodule
